// File: rtl/inst_fetch_unit_if.sv
// Purpose : Bundles the instruction fetch unit's datapath-side handshake and
//           instruction-memory bus into one interface.
// Modports: master - the fetch unit (drives inst_*, mem_req/mem_addr)
//           slave  - the environment (datapath + instruction memory)
// Signals : redirect/redirect_pc  next-PC override from the datapath
//           inst_valid/inst_ready handshake with {inst, inst_pc} payload
//           mem_req/mem_gnt/mem_addr request channel, mem_rvalid/mem_rdata return
`timescale 1ns/1ps
interface inst_fetch_unit_if;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_ready;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        input  redirect, redirect_pc, inst_ready, mem_gnt, mem_rvalid, mem_rdata,
        output inst_valid, inst, inst_pc, mem_req, mem_addr
    );

    modport slave (
        output redirect, redirect_pc, inst_ready, mem_gnt, mem_rvalid, mem_rdata,
        input  inst_valid, inst, inst_pc, mem_req, mem_addr
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// Purpose : Instruction fetch front end. Generates sequential fetch PCs, issues
//           word reads to a variable-latency instruction memory, pairs each
//           returned word with its PC and buffers it in order for the datapath.
//           A redirect loads a new fetch PC and discards everything in flight.
// Ports   : clk  - rising-edge clock
//           rst  - asynchronous, active-low reset
//           bus  - inst_fetch_unit_if.master (redirect, instruction handshake,
//                  instruction-memory request/return)
`timescale 1ns/1ps
module inst_fetch_unit #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input logic               clk,
    input logic               rst,
    inst_fetch_unit_if.master bus
);
    localparam int          CW  = $clog2(DEPTH + 1);
    localparam int          PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW:0] CAP = (CW + 1)'(DEPTH);

    // Scalar state
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] out_q,      out_d;      // granted, not yet returned
    logic [CW-1:0] drop_q,     drop_d;     // returns still to be discarded
    logic [CW-1:0] count_q,    count_d;    // buffered words

    // Tag FIFO (PCs of live requests) and instruction buffer
    logic [PW-1:0] tag_wr_q, tag_rd_q, buf_wr_q, buf_rd_q;
    logic [31:0]   tag_pc_q   [DEPTH];
    logic [31:0]   buf_pc_q   [DEPTH];
    logic [31:0]   buf_data_q [DEPTH];

    logic        redirect;
    logic [31:0] target_pc;
    logic [1:0]  unused_pc_lsbs;
    logic        rsp, drop, push, pop, grant;
    logic [CW:0] used;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign redirect       = bus.redirect;
    assign target_pc      = {bus.redirect_pc[31:2], 2'b00};
    assign unused_pc_lsbs = bus.redirect_pc[1:0];

    // A return with nothing outstanding is spurious and ignored.
    assign rsp  = bus.mem_rvalid && (out_q != '0);
    assign drop = rsp && (drop_q != '0);
    assign push = rsp && (drop_q == '0) && !redirect;
    assign pop  = (count_q != '0) && bus.inst_ready && !redirect;

    // Slots committed to in-flight plus buffered words. A head entry leaving
    // this cycle frees its slot, which keeps a single-cycle memory streaming
    // one instruction per cycle; the buffer can still never overflow.
    assign used        = {1'b0, out_q} + {1'b0, count_q} - {{CW{1'b0}}, pop};
    assign bus.mem_req = rst && !redirect && (used < CAP);
    assign grant       = bus.mem_req && bus.mem_gnt;

    assign bus.mem_addr   = fetch_pc_q;
    assign bus.inst_valid = (count_q != '0);
    assign bus.inst       = buf_data_q[buf_rd_q];
    assign bus.inst_pc    = buf_pc_q[buf_rd_q];

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        fetch_pc_d = grant ? fetch_pc_q + 32'd4 : fetch_pc_q;
        out_d      = out_q + CW'(grant) - CW'(rsp);
        drop_d     = drop_q - CW'(drop);
        count_d    = count_q + CW'(push) - CW'(pop);
        if (redirect) begin
            // No grant can occur here, so every request still in flight after
            // this edge (already-dropped ones included) is discarded: the drop
            // count becomes exactly the post-edge in-flight count.
            fetch_pc_d = target_pc;
            drop_d     = out_q - CW'(rsp);
            count_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            out_q      <= '0;
            drop_q     <= '0;
            count_q    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            fetch_pc_q <= fetch_pc_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_wr_q <= '0;
            tag_rd_q <= '0;
            buf_wr_q <= '0;
            buf_rd_q <= '0;
            // NOTE: the buffer is only DEPTH entries and drives inst/inst_pc directly,
            // so it is reset to give defined (zero) outputs out of reset.
            for (int i = 0; i < DEPTH; i++) begin
                tag_pc_q[i]   <= '0;
                buf_pc_q[i]   <= '0;
                buf_data_q[i] <= '0;
            end
        end else if (redirect) begin
            tag_wr_q <= '0;
            tag_rd_q <= '0;
            buf_wr_q <= '0;
            buf_rd_q <= '0;
        end else begin
            if (grant) begin
                tag_pc_q[tag_wr_q] <= fetch_pc_q;
                tag_wr_q           <= ptr_inc(tag_wr_q);
            end
            if (push) begin
                buf_pc_q[buf_wr_q]   <= tag_pc_q[tag_rd_q];
                buf_data_q[buf_wr_q] <= bus.mem_rdata;
                buf_wr_q             <= ptr_inc(buf_wr_q);
                tag_rd_q             <= ptr_inc(tag_rd_q);
            end
            if (pop) begin
                buf_rd_q <= ptr_inc(buf_rd_q);
            end
        end
    end
endmodule
